// File: rtl/reg_read_port.sv
// reg_read_port: sequenced read port for a bank of registers sharing one read
// bitline. Requests are accepted on a valid/ready handshake and held one cycle
// in S1, where a one-hot read enable is driven and the bitline is sampled.
// Sampled results go into a 2-entry response FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable. Ready never
// depends on the partner's valid in the same cycle. This holds on the request
// side (req_*) and on the response side (rsp_*).
module reg_read_port #(
    parameter int NREGS = 16,
    parameter int WIDTH = 4,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    output logic [NREGS-1:0] ren,
    input  logic [WIDTH-1:0] bitline,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [AW-1:0]    rsp_addr,
    output logic             rsp_err
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    // S1 stage: one in-flight read
    logic          s1_valid_q, s1_valid_d;
    logic [AW-1:0] s1_addr_q,  s1_addr_d;

    // Response FIFO storage and bookkeeping
    logic [WIDTH-1:0] q_data_q [2];
    logic [AW-1:0]    q_addr_q [2];
    logic             q_err_q  [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q,  count_d;

    logic             s1_err;
    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    // Handshake, credit and push/pop decisions
    always_comb begin
        s1_err    = ({1'b0, s1_addr_q} >= NREGS_W);
        // The credit counts the in-flight S1 read, so a queue slot is always
        // reserved for it and the FIFO cannot overflow.
        req_ready = rst && (({1'b0, count_q} + {2'b00, s1_valid_q}) < 3'd2);
        accept    = req_valid && req_ready;
        rsp_valid = rst && (count_q != 2'd0);
        pop       = rsp_valid && rsp_ready;
        push      = s1_valid_q;
        // A write landing in the S1 cycle is not yet visible on the bitline,
        // so it is forwarded from the write port instead.
        if (s1_err) begin
            push_data = '0;
        end else if (wr_en && (wr_addr == s1_addr_q)) begin
            push_data = wr_data;
        end else begin
            push_data = bitline;
        end
        s1_valid_d = accept;
        s1_addr_d  = accept ? req_addr : s1_addr_q;
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
    end

    // One-hot read enable for the S1 address; nothing for out-of-range or idle
    always_comb begin
        ren = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rst && s1_valid_q && !s1_err && (s1_addr_q == AW'(i))) begin
                ren[i] = 1'b1;
            end
        end
    end

    // Response outputs mirror the FIFO head and read as zero when empty
    always_comb begin
        rsp_data = '0;
        rsp_addr = '0;
        rsp_err  = 1'b0;
        if (rsp_valid) begin
            rsp_data = q_data_q[rd_ptr_q];
            rsp_addr = q_addr_q[rd_ptr_q];
            rsp_err  = q_err_q[rd_ptr_q];
        end
    end

    // Pipeline and FIFO state; reset drops every in-flight and queued read
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push) begin
                q_data_q[wr_ptr_q] <= push_data;
                q_addr_q[wr_ptr_q] <= s1_addr_q;
                q_err_q[wr_ptr_q]  <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// Testbench for reg_read_port: models the register bank and checks every
// cycle against a transaction-level model of the port.
module tb_reg_read_port;

    localparam int NREGS = 12;
    localparam int WIDTH = 4;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic [NREGS-1:0] ren;
    logic [WIDTH-1:0] bitline;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [AW-1:0]    rsp_addr;
    logic             rsp_err;

    reg_read_port #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .ren(ren), .bitline(bitline),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- register bank model ----------------
    logic [WIDTH-1:0] bank [NREGS];
    logic [WIDTH-1:0] junk;

    always @(posedge clk) begin
        junk <= WIDTH'($urandom);
        if (wr_en && (int'(wr_addr) < NREGS)) bank[wr_addr] <= wr_data;
    end

    // Undriven bitline carries garbage so errored reads cannot pass by luck
    always_comb begin
        bitline = '0;
        for (int i = 0; i < NREGS; i++) if (ren[i]) bitline = bitline | bank[i];
        if (ren == '0) bitline = junk;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Entry packing: {err, addr, data}
    logic [WIDTH+AW:0] exp_q[$];
    logic              m_s1_v = 1'b0;
    logic [AW-1:0]     m_s1_a = '0;
    logic              m_rdy, m_rv, m_err;
    logic [WIDTH+AW:0] m_head;
    logic [31:0]       m_ren;
    logic [WIDTH-1:0]  m_data;

    always @(negedge clk) begin
        m_rdy  = rst && ((exp_q.size() + (m_s1_v ? 1 : 0)) < 2);
        m_rv   = rst && (exp_q.size() > 0);
        m_head = m_rv ? exp_q[0] : '0;
        m_ren  = (rst && m_s1_v && (int'(m_s1_a) < NREGS)) ? (32'd1 << m_s1_a) : 32'd0;

        check_eq("req_ready", 32'(req_ready), 32'(m_rdy));
        check_eq("ren",       32'(ren),       m_ren);
        check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check_eq("rsp_data",  32'(rsp_data),  32'(m_head[WIDTH-1:0]));
        check_eq("rsp_addr",  32'(rsp_addr),  32'(m_head[WIDTH+AW-1:WIDTH]));
        check_eq("rsp_err",   32'(rsp_err),   32'(m_head[WIDTH+AW]));

        if (!rst) begin
            exp_q.delete();
            m_s1_v = 1'b0;
        end else begin
            if (m_rv && rsp_ready) void'(exp_q.pop_front());
            if (m_s1_v) begin
                m_err = int'(m_s1_a) >= NREGS;
                if (m_err) m_data = '0;
                else if (wr_en && wr_addr == m_s1_a) m_data = wr_data;
                else m_data = bank[m_s1_a];
                exp_q.push_back({m_err, m_s1_a, m_data});
            end
            m_s1_v = req_valid && m_rdy;
            m_s1_a = req_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    // Returns one time step after the accepting edge, i.e. inside the S1 cycle
    task automatic issue(input logic [AW-1:0] a);
        int n;
        req_valid = 1'b1; req_addr = a;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("issue_timeout", 32'd0, 32'd1);
        tick(1);
        req_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; req_valid = 1'b1; req_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;

        // Reset held with a pending request
        tick(3);
        rst = 1'b1; req_valid = 1'b0;
        for (int i = 0; i < NREGS; i++) write_reg(AW'(i), WIDTH'(i));

        // Single read
        write_reg(4'd5, 4'hA);
        issue(4'd5);
        tick(3);

        // Streaming 0..15 with consumer always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1; req_addr = AW'(i);
            tick(1);
        end
        req_valid = 1'b0;
        tick(4);

        // Backpressure: two accepted, the third waits for a credit
        rsp_ready = 1'b0;
        issue(4'd1);
        issue(4'd2);
        req_valid = 1'b1; req_addr = 4'd6;
        tick(4);
        rsp_ready = 1'b1;
        issue(4'd6);
        tick(4);

        // Bypass hit and miss
        write_reg(4'd3, 4'h1);
        issue(4'd3);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'h7;
        tick(1);
        wr_en = 1'b0;
        tick(3);
        write_reg(4'd3, 4'h1);
        issue(4'd3);
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 4'h7;
        tick(1);
        wr_en = 1'b0;
        tick(3);

        // Out-of-range address
        issue(4'd13);
        tick(3);

        // Reset with reads queued and in flight
        rsp_ready = 1'b0;
        issue(4'd1);
        issue(4'd2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1; rsp_ready = 1'b1;
        tick(4);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = AW'($urandom_range(0, 15));
            wr_data   = WIDTH'($urandom);
            if ($urandom_range(0, 60) == 0) rst = 1'b0;
            else rst = 1'b1;
            tick(1);
        end
        rst = 1'b1; req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
